// File: rtl/complex_mult_seq.sv
// Sequential signed complex multiplier: (ar + j*ai)*(br + j*bi) using one shared
// 8x8 signed multiplier stepped over four cycles by a two-state FSM.
module complex_mult_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [7:0]  ar,
    input  logic signed [7:0]  ai,
    input  logic signed [7:0]  br,
    input  logic signed [7:0]  bi,
    output logic               busy,
    output logic               done,
    output logic signed [16:0] re,
    output logic signed [16:0] im
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic   accept, last;

    logic        [1:0]  k;
    logic signed [7:0]  ar_q, ai_q, br_q, bi_q;
    logic               sel_a, sel_b;
    logic signed [7:0]  mux_a, mux_b;
    logic signed [15:0] mul_a, mul_b, prod;
    logic signed [16:0] prod_ext;
    logic signed [16:0] acc_re, acc_im, acc_re_nxt, acc_im_nxt;

    // k walks (sel_a, sel_b) through (0,0) (1,1) (0,1) (1,0): ar*br, ai*bi, ar*bi, ai*br
    assign sel_a = k[0];
    assign sel_b = k[1] ^ k[0];
    assign mux_a = sel_a ? ai_q : ar_q;
    assign mux_b = sel_b ? bi_q : br_q;

    assign mul_a    = {{8{mux_a[7]}}, mux_a};
    assign mul_b    = {{8{mux_b[7]}}, mux_b};
    assign prod     = mul_a * mul_b;
    assign prod_ext = {prod[15], prod};

    assign busy = (state == RUN);

    always_comb begin
        acc_re_nxt = acc_re;
        acc_im_nxt = acc_im;
        case (k)
            2'd0:    acc_re_nxt = acc_re + prod_ext;
            2'd1:    acc_re_nxt = acc_re - prod_ext;
            default: acc_im_nxt = acc_im + prod_ext;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_nxt = RUN;
                accept    = 1'b1;
            end
        end else begin
            if (k == 2'd3) begin
                state_nxt = IDLE;
                last      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k      <= 2'd0;
            ar_q   <= '0;
            ai_q   <= '0;
            br_q   <= '0;
            bi_q   <= '0;
            acc_re <= '0;
            acc_im <= '0;
            re     <= '0;
            im     <= '0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                ar_q   <= ar;
                ai_q   <= ai;
                br_q   <= br;
                bi_q   <= bi;
                acc_re <= '0;
                acc_im <= '0;
                k      <= 2'd0;
            end else if (state == RUN) begin
                acc_re <= acc_re_nxt;
                acc_im <= acc_im_nxt;
                k      <= k + 2'd1;
                // outputs only move on the final step, so re/im stay stable during RUN
                if (last) begin
                    re <= acc_re_nxt;
                    im <= acc_im_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed bench for complex_mult_seq: hand-computed complex products, step
// select sequence, start-while-busy, back-to-back starts and mid-run reset.
module tb_complex_mult_seq;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [7:0]  ar, ai, br, bi;
    logic               busy, done;
    logic signed [16:0] re, im;

    int checks = 0;
    int errors = 0;
    int last_re = 0;
    int last_im = 0;

    complex_mult_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ar    (ar),
        .ai    (ai),
        .br    (br),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .re    (re),
        .im    (im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input int a_r, input int a_i, input int b_r, input int b_i);
        ar = 8'(a_r);
        ai = 8'(a_i);
        br = 8'(b_r);
        bi = 8'(b_i);
    endtask

    // state sampled just after an edge that left k at the given step
    task automatic step_check(input string tag, input int sa, input int sb);
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " done"}, int'(done), 0);
        check({tag, " sel_a"}, int'(dut.sel_a), sa);
        check({tag, " sel_b"}, int'(dut.sel_b), sb);
        check({tag, " re hold"}, int'($signed(re)), last_re);
        check({tag, " im hold"}, int'($signed(im)), last_im);
    endtask

    task automatic done_check(input string tag, input int exp_re, input int exp_im);
        check({tag, " done"}, int'(done), 1);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " re"}, int'($signed(re)), exp_re);
        check({tag, " im"}, int'($signed(im)), exp_im);
        last_re = exp_re;
        last_im = exp_im;
    endtask

    // one full operation from idle with a single-cycle start pulse
    task automatic run_op(input string tag, input int a_r, input int a_i, input int b_r,
                          input int b_i, input int exp_re, input int exp_im);
        drive_ops(a_r, a_i, b_r, b_i);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_ops(0, 0, 0, 0);
        step_check({tag, " k0"}, 0, 0);
        tick();
        step_check({tag, " k1"}, 1, 1);
        tick();
        step_check({tag, " k2"}, 0, 1);
        tick();
        step_check({tag, " k3"}, 1, 0);
        tick();
        done_check(tag, exp_re, exp_im);
        tick();
        check({tag, " done pulse width"}, int'(done), 0);
        check({tag, " idle busy"}, int'(busy), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        drive_ops(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset re", int'($signed(re)), 0);
        check("reset im", int'($signed(im)), 0);
        tick();

        // basic product and full-range sign extension
        run_op("3+4j*5+6j", 3, 4, 5, 6, -9, 38);
        run_op("-128-128j sq", -128, -128, -128, -128, 0, 32768);
        run_op("-128+127j*-128-127j", -128, 127, -128, -127, 32513, 0);

        // second start at T2 must be ignored
        drive_ops(1, 2, 3, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_ops(7, 7, 7, 7);
        step_check("ignore k0", 0, 0);
        tick();
        step_check("ignore k1", 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        step_check("ignore k2", 0, 1);
        tick();
        step_check("ignore k3", 1, 0);
        tick();
        done_check("ignore", -5, 10);
        tick();
        check("ignore no requeue busy", int'(busy), 0);
        check("ignore single done", int'(done), 0);
        tick();
        check("ignore still idle", int'(busy), 0);

        // start held high: five back-to-back operations, done every 5 cycles
        start = 1'b1;
        drive_ops(1, 1, 1, 1);
        tick();
        step_check("b2b0 k0", 0, 0);
        repeat (3) tick();
        check("b2b0 pre done", int'(done), 0);
        tick();
        done_check("b2b0", 0, 2);
        drive_ops(2, -3, 4, 5);
        tick();
        step_check("b2b1 k0", 0, 0);
        repeat (3) tick();
        check("b2b1 pre done", int'(done), 0);
        tick();
        done_check("b2b1", 23, -2);
        drive_ops(-7, 0, 9, -2);
        tick();
        step_check("b2b2 k0", 0, 0);
        repeat (3) tick();
        check("b2b2 pre done", int'(done), 0);
        tick();
        done_check("b2b2", -63, 14);
        drive_ops(100, 50, -20, 10);
        tick();
        step_check("b2b3 k0", 0, 0);
        repeat (3) tick();
        check("b2b3 pre done", int'(done), 0);
        tick();
        done_check("b2b3", -2500, 0);
        drive_ops(127, 127, 127, 127);
        tick();
        step_check("b2b4 k0", 0, 0);
        repeat (3) tick();
        check("b2b4 pre done", int'(done), 0);
        tick();
        start = 1'b0;
        done_check("b2b4", 0, 32258);
        tick();
        check("b2b end busy", int'(busy), 0);
        check("b2b end done", int'(done), 0);

        // asynchronous reset between T2 and T3 aborts the operation
        drive_ops(5, 5, 5, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        step_check("abort k2", 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort re", int'($signed(re)), 0);
        check("abort im", int'($signed(im)), 0);
        tick();
        rst = 1'b0;
        last_re = 0;
        last_im = 0;
        tick();
        check("abort no done 1", int'(done), 0);
        tick();
        check("abort no done 2", int'(done), 0);
        check("abort idle", int'(busy), 0);
        run_op("after abort", 2, 3, 4, -1, 11, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
